// File: rtl/avl_mem_pkg.sv
// Shared defaults and FSM state encoding for the on-chip DDR4 Avalon-MM responder.
package avl_mem_pkg;

  localparam int unsigned DW_DEF = 512;
  localparam int unsigned AW_DEF = 26;
  localparam int unsigned BW_DEF = 7;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_CAL      = 2'd0;
  localparam logic [ST_W-1:0] ST_IDLE     = 2'd1;
  localparam logic [ST_W-1:0] ST_WR_BURST = 2'd2;
  localparam logic [ST_W-1:0] ST_RD_BURST = 2'd3;

endpackage

// File: rtl/ddr4_avl_mem_responder_if.sv
// Avalon-MM user-side bus between the DDR test/DMA masters and the EMIF (or its stand-in).
interface ddr4_avl_mem_responder_if
  import avl_mem_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned BW = BW_DEF
);

  logic            avl_read_req;
  logic            avl_write_req;
  logic [AW-1:0]   avl_addr;
  logic [BW-1:0]   avl_size;
  logic [DW-1:0]   avl_wdata;
  logic [DW/8-1:0] avl_be;
  logic            avl_ready;
  logic [DW-1:0]   avl_rdata;
  logic            avl_rdata_valid;

  modport master (
    output avl_read_req, avl_write_req, avl_addr, avl_size, avl_wdata, avl_be,
    input  avl_ready, avl_rdata, avl_rdata_valid
  );

  modport slave (
    input  avl_read_req, avl_write_req, avl_addr, avl_size, avl_wdata, avl_be,
    output avl_ready, avl_rdata, avl_rdata_valid
  );

endinterface

// File: rtl/avl_resp_bram.sv
// Single-port RAM with per-byte write enables and a registered read port.
module avl_resp_bram #(
  parameter int unsigned DW         = 512,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DW-1:0]         wdata,
  input  logic [DW/8-1:0]       be,
  output logic [DW-1:0]         q
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DW-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (re) q <= mem[addr];
  end

endmodule

// File: rtl/ddr4_avl_mem_responder.sv
// Avalon-MM burst responder backed by on-chip RAM, standing in for the DDR4 EMIF controller.
module ddr4_avl_mem_responder
  import avl_mem_pkg::*;
#(
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned BW          = BW_DEF,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned CAL_CYCLES  = 64,
  parameter int unsigned STALL_EVERY = 0
) (
  input  logic                     sync_clk,
  input  logic                     reset_n,
  ddr4_avl_mem_responder_if.slave  avl,
  output logic                     local_cal_success,
  output logic                     local_cal_fail,
  output logic                     protocol_err
);

  localparam int unsigned DL         = DEPTH_LOG2;
  localparam int unsigned CAL_N      = (CAL_CYCLES == 0) ? 1 : CAL_CYCLES;
  localparam int unsigned CW         = (CAL_N > 1) ? $clog2(CAL_N) : 1;
  localparam int unsigned SCW        = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
  localparam logic [CW-1:0]  CAL_LAST   = CW'(CAL_N - 1);
  localparam logic [SCW-1:0] STALL_LAST = SCW'((STALL_EVERY == 0) ? 0 : STALL_EVERY - 1);

  logic [ST_W-1:0] state_q, state_d;
  logic [CW-1:0]   cal_cnt_q, cal_cnt_d;
  logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;
  logic            ready_q, ready_d;
  logic            cal_ok_q, cal_ok_d;
  logic            perr_q, perr_d;
  logic [DL-1:0]   addr_q, addr_d;
  logic [BW-1:0]   wr_left_q, wr_left_d;
  logic [BW-1:0]   rd_issue_q, rd_issue_d;
  logic [BW-1:0]   rd_out_q, rd_out_d;

  logic [BW-1:0]   size_eff_c;
  logic            wr_acc_c, rd_acc_c, stall_hit_c;
  logic            mem_we_c, mem_re_c;
  logic [DL-1:0]   mem_addr_c;
  logic [DW-1:0]   bram_q;
  logic [RD_LATENCY-1:0] vld_q;
  logic            unused_addr_c;

  assign unused_addr_c = ^avl.avl_addr[AW-1:DL];

  // Next-state, handshake and RAM port control.
  always_comb begin
    state_d     = state_q;
    cal_cnt_d   = cal_cnt_q;
    stall_cnt_d = stall_cnt_q;
    ready_d     = ready_q;
    cal_ok_d    = cal_ok_q;
    perr_d      = perr_q;
    addr_d      = addr_q;
    wr_left_d   = wr_left_q;
    rd_issue_d  = rd_issue_q;
    rd_out_d    = rd_out_q;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_addr_c  = addr_q;
    stall_hit_c = 1'b0;

    size_eff_c = (avl.avl_size == '0) ? BW'(1) : avl.avl_size;
    wr_acc_c   = avl.avl_write_req && ready_q &&
                 ((state_q == ST_IDLE) || (state_q == ST_WR_BURST));
    rd_acc_c   = avl.avl_read_req && !avl.avl_write_req && ready_q && (state_q == ST_IDLE);

    // Every STALL_EVERY accepted write beats cost one cycle of avl_ready low.
    if ((STALL_EVERY != 0) && wr_acc_c) begin
      if (stall_cnt_q == STALL_LAST) begin
        stall_cnt_d = '0;
        stall_hit_c = 1'b1;
      end else begin
        stall_cnt_d = stall_cnt_q + SCW'(1);
      end
    end

    case (state_q)
      ST_CAL: begin
        cal_cnt_d = cal_cnt_q + CW'(1);
        if (cal_cnt_q == CAL_LAST) begin
          state_d  = ST_IDLE;
          cal_ok_d = 1'b1;
          ready_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        ready_d = 1'b1;
        if (wr_acc_c) begin
          mem_we_c   = 1'b1;
          mem_addr_c = avl.avl_addr[DL-1:0];
          addr_d     = avl.avl_addr[DL-1:0] + DL'(1);
          wr_left_d  = size_eff_c - BW'(1);
          if (avl.avl_read_req) perr_d = 1'b1;
          if (size_eff_c != BW'(1)) state_d = ST_WR_BURST;
        end else if (rd_acc_c) begin
          mem_re_c   = 1'b1;
          mem_addr_c = avl.avl_addr[DL-1:0];
          addr_d     = avl.avl_addr[DL-1:0] + DL'(1);
          rd_issue_d = size_eff_c - BW'(1);
          rd_out_d   = size_eff_c;
          ready_d    = 1'b0;
          state_d    = ST_RD_BURST;
        end
      end
      ST_WR_BURST: begin
        ready_d = 1'b1;
        if (wr_acc_c) begin
          mem_we_c   = 1'b1;
          mem_addr_c = addr_q;
          addr_d     = addr_q + DL'(1);
          wr_left_d  = wr_left_q - BW'(1);
          if (wr_left_q == BW'(1)) state_d = ST_IDLE;
        end
      end
      ST_RD_BURST: begin
        ready_d = 1'b0;
        if (rd_issue_q != '0) begin
          mem_re_c   = 1'b1;
          mem_addr_c = addr_q;
          addr_d     = addr_q + DL'(1);
          rd_issue_d = rd_issue_q - BW'(1);
        end
        // Leave on the last delivered beat so avl_ready rises the cycle after it.
        if (vld_q[RD_LATENCY-1]) begin
          rd_out_d = rd_out_q - BW'(1);
          if (rd_out_q == BW'(1)) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
          end
        end
      end
      default: state_d = ST_CAL;
    endcase

    if (stall_hit_c) ready_d = 1'b0;
  end

  always_ff @(posedge sync_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CAL;
      cal_cnt_q   <= '0;
      stall_cnt_q <= '0;
      ready_q     <= 1'b0;
      cal_ok_q    <= 1'b0;
      perr_q      <= 1'b0;
      addr_q      <= '0;
      wr_left_q   <= '0;
      rd_issue_q  <= '0;
      rd_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cal_cnt_q   <= cal_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      ready_q     <= ready_d;
      cal_ok_q    <= cal_ok_d;
      perr_q      <= perr_d;
      addr_q      <= addr_d;
      wr_left_q   <= wr_left_d;
      rd_issue_q  <= rd_issue_d;
      rd_out_q    <= rd_out_d;
    end
  end

  avl_resp_bram #(
    .DW         (DW),
    .DEPTH_LOG2 (DL)
  ) u_bram (
    .clk   (sync_clk),
    .rst_n (reset_n),
    .we    (mem_we_c),
    .re    (mem_re_c),
    .addr  (mem_addr_c),
    .wdata (avl.avl_wdata),
    .be    (avl.avl_be),
    .q     (bram_q)
  );

  // Valid tracks the RAM read register plus RD_LATENCY-1 extra stages.
  always_ff @(posedge sync_clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= mem_re_c;
      for (int i = 1; i < RD_LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign avl.avl_rdata = bram_q;
    end else begin : g_latn
      logic [DW-1:0] dpipe_q [RD_LATENCY-1];
      always_ff @(posedge sync_clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < RD_LATENCY - 1; i++) dpipe_q[i] <= '0;
        end else begin
          dpipe_q[0] <= bram_q;
          for (int i = 1; i < RD_LATENCY - 1; i++) dpipe_q[i] <= dpipe_q[i-1];
        end
      end
      assign avl.avl_rdata = dpipe_q[RD_LATENCY-2];
    end
  endgenerate

  assign avl.avl_ready       = ready_q;
  assign avl.avl_rdata_valid = vld_q[RD_LATENCY-1];
  assign local_cal_success   = cal_ok_q;
  assign local_cal_fail      = 1'b0;
  assign protocol_err        = perr_q;

endmodule

// File: tb/tb_ddr4_avl_mem_responder.sv
// Directed bench: one responder with default settings, one with STALL_EVERY=2.
module tb_ddr4_avl_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ddr4_avl_mem_responder_if #(.DW(512), .AW(26), .BW(7)) b0 ();
  ddr4_avl_mem_responder_if #(.DW(512), .AW(26), .BW(7)) b1 ();

  logic cal0, fail0, perr0, cal1, fail1, perr1;

  ddr4_avl_mem_responder dut (
    .sync_clk          (clk),
    .reset_n           (rst_n),
    .avl               (b0.slave),
    .local_cal_success (cal0),
    .local_cal_fail    (fail0),
    .protocol_err      (perr0)
  );

  ddr4_avl_mem_responder #(.STALL_EVERY(2)) dut_st (
    .sync_clk          (clk),
    .reset_n           (rst_n),
    .avl               (b1.slave),
    .local_cal_success (cal1),
    .local_cal_fail    (fail1),
    .protocol_err      (perr1)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b1.avl_ready : b0.avl_ready;
  endfunction

  function automatic logic vld(input bit sel);
    return sel ? b1.avl_rdata_valid : b0.avl_rdata_valid;
  endfunction

  function automatic logic [511:0] rdat(input bit sel);
    return sel ? b1.avl_rdata : b0.avl_rdata;
  endfunction

  task automatic drive_rd(input bit sel, input logic r, input logic [25:0] a, input logic [6:0] sz);
    if (sel) begin
      b1.avl_read_req = r; b1.avl_addr = a; b1.avl_size = sz;
    end else begin
      b0.avl_read_req = r; b0.avl_addr = a; b0.avl_size = sz;
    end
  endtask

  // Write burst on b0: beat i carries base+i; b0 never stalls.
  task automatic wr_burst(input logic [25:0] a, input logic [6:0] sz, input int nb,
                          input logic [511:0] base, input logic [63:0] be, input string tag);
    for (int i = 0; i < nb; i++) begin
      b0.avl_write_req = 1'b1;
      b0.avl_addr      = a;
      b0.avl_size      = sz;
      b0.avl_wdata     = base + 512'(i);
      b0.avl_be        = be;
      check1({tag, "_wr_rdy"}, b0.avl_ready, 1'b1);
      @(negedge clk);
    end
    b0.avl_write_req = 1'b0;
  endtask

  // Read burst: data expected as base+k at accept+2+k, ready low until after the last beat.
  task automatic rd_check(input bit sel, input logic [25:0] a, input logic [6:0] sz, input int nb,
                          input logic [511:0] base, input string tag);
    drive_rd(sel, 1'b1, a, sz);
    check1({tag, "_rd_rdy"}, rdy(sel), 1'b1);
    @(negedge clk);
    drive_rd(sel, 1'b0, a, sz);
    check1({tag, "_lat_vld"}, vld(sel), 1'b0);
    check1({tag, "_lat_rdy"}, rdy(sel), 1'b0);
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      check1({tag, "_beat_vld"}, vld(sel), 1'b1);
      check({tag, "_beat_data"}, rdat(sel), base + 512'(k));
      check1({tag, "_beat_rdy"}, rdy(sel), 1'b0);
    end
    @(negedge clk);
    check1({tag, "_end_vld"}, vld(sel), 1'b0);
    check1({tag, "_end_rdy"}, rdy(sel), 1'b1);
  endtask

  initial begin
    logic [511:0] pre, merged;
    pre    = {64{8'h11}};
    merged = {{63{8'h11}}, 8'hFF};

    rst_n = 1'b0;
    b0.avl_read_req = 1'b0; b0.avl_write_req = 1'b0; b0.avl_addr = '0; b0.avl_size = '0;
    b0.avl_wdata = '0; b0.avl_be = '0;
    b1.avl_read_req = 1'b0; b1.avl_write_req = 1'b0; b1.avl_addr = '0; b1.avl_size = '0;
    b1.avl_wdata = '0; b1.avl_be = '0;
    repeat (3) @(negedge clk);

    check1("rst_ready", b0.avl_ready, 1'b0);
    check1("rst_valid", b0.avl_rdata_valid, 1'b0);
    check("rst_rdata", b0.avl_rdata, '0);
    check1("rst_cal", cal0, 1'b0);
    check1("rst_cal_fail", fail0, 1'b0);
    check1("rst_perr", perr0, 1'b0);

    // Calibration: 64 cycles after release
    rst_n = 1'b1;
    repeat (63) @(negedge clk);
    check1("cal63_ready", b0.avl_ready, 1'b0);
    check1("cal63_cal", cal0, 1'b0);
    @(negedge clk);
    check1("cal64_ready", b0.avl_ready, 1'b1);
    check1("cal64_cal", cal0, 1'b1);
    check1("cal64_cal_st", cal1, 1'b1);

    // Burst write then read-after-write
    wr_burst(26'h10, 7'd4, 4, 512'hA0, '1, "b4");
    rd_check(1'b0, 26'h10, 7'd4, 4, 512'hA0, "rb4");

    // Byte-enable merge
    wr_burst(26'h20, 7'd1, 1, pre, '1, "pre");
    wr_burst(26'h20, 7'd1, 1, 512'hFF, 64'h1, "be");
    rd_check(1'b0, 26'h20, 7'd1, 1, merged, "rbe");

    // Wrap at RAM end, then size 0 treated as 1
    wr_burst(26'd1023, 7'd3, 3, 512'hC0, '1, "wrap");
    rd_check(1'b0, 26'd1023, 7'd3, 3, 512'hC0, "rwrap");
    rd_check(1'b0, 26'd0, 7'd2, 2, 512'hC1, "rwrap0");
    rd_check(1'b0, 26'h10, 7'd0, 1, 512'hA0, "rsz0");
    check1("perr_clean", perr0, 1'b0);

    // Simultaneous read and write
    b0.avl_read_req = 1'b1; b0.avl_write_req = 1'b1; b0.avl_addr = 26'h30;
    b0.avl_size = 7'd1; b0.avl_wdata = 512'h55; b0.avl_be = '1;
    check1("both_rdy", b0.avl_ready, 1'b1);
    @(negedge clk);
    b0.avl_read_req = 1'b0; b0.avl_write_req = 1'b0;
    check1("both_perr", perr0, 1'b1);
    check1("both_no_rd_rdy", b0.avl_ready, 1'b1);
    @(negedge clk);
    check1("both_no_rd_vld", b0.avl_rdata_valid, 1'b0);
    rd_check(1'b0, 26'h30, 7'd1, 1, 512'h55, "rboth");
    check1("perr_sticky", perr0, 1'b1);

    // Write stall every 2 beats on the second responder
    for (int i = 0; i < 6; i++) begin
      b1.avl_write_req = 1'b1; b1.avl_addr = 26'h40; b1.avl_size = 7'd6;
      b1.avl_wdata = 512'hE0 + 512'(i); b1.avl_be = '1;
      check1("st_beat_rdy", b1.avl_ready, 1'b1);
      @(negedge clk);
      if ((i % 2) == 1) begin
        check1("st_stall", b1.avl_ready, 1'b0);
        @(negedge clk);
      end
    end
    b1.avl_write_req = 1'b0;
    check1("st_after_rdy", b1.avl_ready, 1'b1);
    rd_check(1'b1, 26'h40, 7'd6, 6, 512'hE0, "rst6");

    // Reset in the middle of a read burst
    drive_rd(1'b0, 1'b1, 26'h10, 7'd8);
    check1("mid_rdy", b0.avl_ready, 1'b1);
    @(negedge clk);
    drive_rd(1'b0, 1'b0, 26'h10, 7'd8);
    @(negedge clk);
    check1("mid_vld", b0.avl_rdata_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("mid_rst_ready", b0.avl_ready, 1'b0);
    check1("mid_rst_valid", b0.avl_rdata_valid, 1'b0);
    check("mid_rst_rdata", b0.avl_rdata, '0);
    check1("mid_rst_cal", cal0, 1'b0);
    check1("mid_rst_perr", perr0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (63) @(negedge clk);
    check1("recal63_ready", b0.avl_ready, 1'b0);
    @(negedge clk);
    check1("recal64_ready", b0.avl_ready, 1'b1);
    check1("recal64_cal", cal0, 1'b1);
    rd_check(1'b0, 26'h10, 7'd4, 4, 512'hA0, "rkeep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
